// File: rtl/receiving_fsm_pkg.sv
// Shared IO hub constants for the byte-to-word receive path.
// State codes match the transmitter's tr_h/tr_l encoding.
package receiving_fsm_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned BYTE_W = 8;

  localparam logic ST_WAIT_H = 1'b0;
  localparam logic ST_WAIT_L = 1'b1;

  typedef enum logic {
    StWaitH = ST_WAIT_H,
    StWaitL = ST_WAIT_L
  } rx_state_e;

endpackage

// File: rtl/receiving_fsm_if.sv
// Byte input and word output handshake of the receiving FSM.
// The producer/consumer side uses master; the receiver uses slave.
interface receiving_fsm_if;
  import receiving_fsm_pkg::*;

  logic [BYTE_W-1:0] rx_byte;
  logic              rx_valid;
  logic [WORD_W-1:0] word;
  logic              word_valid;
  logic              word_ready;

  modport master (
    output rx_byte,
    output rx_valid,
    output word_ready,
    input  word,
    input  word_valid
  );

  modport slave (
    input  rx_byte,
    input  rx_valid,
    input  word_ready,
    output word,
    output word_valid
  );

endinterface

// File: rtl/receiving_fsm_rx_timeout_cnt.sv
// Inter-byte timeout counter: clear wins over enable, expire is combinational
// when the count reaches TIMEOUT_CYCLES-1.
module receiving_fsm_rx_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/receiving_fsm.sv
// Assembles UART bytes (high first) into 16-bit words behind a one-word holding register.
// Optional inter-byte timeout enabled by defining RX_TIMEOUT_EN.
module receiving_fsm
  import receiving_fsm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  receiving_fsm_if.slave rx_if,
  output logic overrun_o,
  input  logic ovr_clr_i,
  output logic timeout_o,
  output logic busy_o
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535 ||
      ((TIMEOUT_CYCLES - 1) >> CNT_W) != 0) begin : g_bad_cfg
    $error("receiving_fsm: TIMEOUT_CYCLES out of range or does not fit CNT_W");
  end

  rx_state_e         state_q, state_d;
  logic [BYTE_W-1:0] hi_q, hi_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              word_valid_q, word_valid_d;
  logic              overrun_q, overrun_d;
  logic              timeout_q, timeout_d;
  logic              expire;

`ifdef RX_TIMEOUT_EN
  logic cnt_clr;
  logic cnt_en;

  // Counter only runs while a low byte is pending; any strobe or expiry restarts it.
  assign cnt_clr = (state_q == StWaitH) | rx_if.rx_valid | expire;
  assign cnt_en  = (state_q == StWaitL);

  receiving_fsm_rx_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_rx_timeout_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .expire_o (expire)
  );
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    word_d       = word_q;
    word_valid_d = word_valid_q;
    overrun_d    = overrun_q;
    timeout_d    = 1'b0;

    if (word_valid_q && rx_if.word_ready) begin
      word_valid_d = 1'b0;
    end
    if (ovr_clr_i) begin
      overrun_d = 1'b0;
    end

    unique case (state_q)
      StWaitH: begin
        if (rx_if.rx_valid) begin
          hi_d    = rx_if.rx_byte;
          state_d = StWaitL;
        end
      end
      StWaitL: begin
        if (rx_if.rx_valid) begin
          state_d = StWaitH;
          // A word consumed this cycle frees the holding register for the new one.
          if (!word_valid_q || rx_if.word_ready) begin
            word_d       = {hi_q, rx_if.rx_byte};
            word_valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end else if (expire) begin
          state_d   = StWaitH;
          hi_d      = '0;
          timeout_d = 1'b1;
        end
      end
      default: state_d = StWaitH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StWaitH;
      hi_q         <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
    end
  end

  assign rx_if.word       = word_q;
  assign rx_if.word_valid = word_valid_q;
  assign overrun_o        = overrun_q;
  assign timeout_o        = timeout_q;
  assign busy_o           = (state_q == StWaitL);

endmodule

// File: tb/tb_receiving_fsm.sv
// Scoreboard bench for receiving_fsm: expected words are queued when the low byte
// is driven and popped when the consumer side completes a handshake.
module tb_receiving_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ovr_clr = 1'b0;
  logic overrun;
  logic timeout;
  logic busy;

  int n_tests = 0;
  int n_fail  = 0;
  int tmo_pulses = 0;
  logic [15:0] exp_q[$];

  receiving_fsm_if bus ();

  receiving_fsm #(
    .TIMEOUT_CYCLES (8),
    .CNT_W          (16)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .rx_if     (bus.slave),
    .overrun_o (overrun),
    .ovr_clr_i (ovr_clr),
    .timeout_o (timeout),
    .busy_o    (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick();
    bus.rx_byte  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  // Handshake monitor: every transfer must match the oldest queued word.
  always @(negedge clk) begin
    if (!rst && timeout) tmo_pulses++;
    if (!rst && bus.word_valid && bus.word_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_word", {16'h0, bus.word}, 32'hFFFF_FFFF);
      end else begin
        check_eq("sb_word", {16'h0, bus.word}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_byte    = 8'h00;
    bus.rx_valid   = 1'b0;
    bus.word_ready = 1'b0;

    // Reset, with a stray strobe that must be ignored.
    tick();
    bus.rx_byte  = 8'hEE;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    tick();
    check_eq("rst_valid", bus.word_valid, 0);
    check_eq("rst_word", bus.word, 0);
    check_eq("rst_overrun", overrun, 0);
    check_eq("rst_timeout", timeout, 0);
    check_eq("rst_busy", busy, 0);
    rst = 1'b0;

    // Basic word, consumer always ready.
    bus.word_ready = 1'b1;
    send_byte(8'hA5);
    check_eq("t1_busy_hi", busy, 1);
    exp_q.push_back(16'hA53C);
    send_byte(8'h3C);
    check_eq("t1_valid", bus.word_valid, 1);
    check_eq("t1_word", bus.word, 16'hA53C);
    check_eq("t1_busy_lo", busy, 0);
    check_eq("t1_overrun", overrun, 0);
    tick();
    check_eq("t1_valid_drop", bus.word_valid, 0);

    // Overrun: second word dropped while the first is held.
    bus.word_ready = 1'b0;
    exp_q.push_back(16'h1234);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    check_eq("t2_word_hold", bus.word, 16'h1234);
    check_eq("t2_valid_hold", bus.word_valid, 1);
    check_eq("t2_overrun", overrun, 1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check_eq("t2_ovr_clr", overrun, 0);
    bus.word_ready = 1'b1;
    tick();
    exp_q.push_back(16'h9ABC);
    send_byte(8'h9A);
    send_byte(8'hBC);
    check_eq("t2_word2", bus.word, 16'h9ABC);
    check_eq("t2_overrun2", overrun, 0);

    // Consume and reload in the same cycle.
    tick();
    bus.word_ready = 1'b0;
    exp_q.push_back(16'h1111);
    send_byte(8'h11);
    send_byte(8'h11);
    send_byte(8'h22);
    tick();
    bus.rx_byte    = 8'h22;
    bus.rx_valid   = 1'b1;
    bus.word_ready = 1'b1;
    exp_q.push_back(16'h2222);
    tick();
    bus.rx_valid   = 1'b0;
    bus.word_ready = 1'b0;
    check_eq("t3_word", bus.word, 16'h2222);
    check_eq("t3_valid", bus.word_valid, 1);
    check_eq("t3_overrun", overrun, 0);

    // Drop and clear in the same cycle: set wins.
    send_byte(8'h33);
    tick();
    bus.rx_byte  = 8'h44;
    bus.rx_valid = 1'b1;
    ovr_clr      = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    ovr_clr      = 1'b0;
    check_eq("t4_set_wins", overrun, 1);
    check_eq("t4_word_hold", bus.word, 16'h2222);
    ovr_clr        = 1'b1;
    bus.word_ready = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check_eq("t4_drained", bus.word_valid, 0);

`ifdef RX_TIMEOUT_EN
    // Timeout after the high byte, then a clean word.
    begin
      int lat;
      lat = 0;
      send_byte(8'hFF);
      for (int i = 1; i <= 20; i++) begin
        tick();
        if (timeout && lat == 0) lat = i;
      end
      check_eq("t5_tmo_latency", lat, 8);
      check_eq("t5_busy", busy, 0);
      check_eq("t5_tmo_pulses", tmo_pulses, 1);
      exp_q.push_back(16'h0102);
      send_byte(8'h01);
      send_byte(8'h02);
      check_eq("t5_word", bus.word, 16'h0102);
    end

    // Low byte in the exact expiry cycle: the byte wins.
    begin
      int before;
      before = tmo_pulses;
      send_byte(8'hAA);
      for (int i = 0; i < 6; i++) tick();
      exp_q.push_back(16'hAA55);
      send_byte(8'h55);
      check_eq("t6_word", bus.word, 16'hAA55);
      for (int i = 0; i < 12; i++) tick();
      check_eq("t6_no_tmo", tmo_pulses, before);
    end
`endif

    // Reset mid-word discards the pending high byte.
    send_byte(8'h77);
    check_eq("t7_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t7_busy_rst", busy, 0);
    check_eq("t7_valid_rst", bus.word_valid, 0);
    exp_q.push_back(16'h0102);
    send_byte(8'h01);
    send_byte(8'h02);
    check_eq("t7_word", bus.word, 16'h0102);
    tick();
    tick();

    check_eq("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
